// File: rtl/tt_pad_pkg.sv
// Shared definitions for the signal-pad controller.
//   - Bit positions inside the 6-bit pad configuration word
//     {pu, pd, cs, sl, ie, oe_en}.
//   - Configuration applied at reset (ie=1, pd=1).
//   - Encoding of the attribute-change sequencer states.
//   - cfg_legal(): pull-up and pull-down must never be enabled together.
package tt_pad_pkg;

    localparam int unsigned CFG_W     = 6;
    localparam int unsigned CFG_OE_EN = 0;
    localparam int unsigned CFG_IE    = 1;
    localparam int unsigned CFG_SL    = 2;
    localparam int unsigned CFG_CS    = 3;
    localparam int unsigned CFG_PD    = 4;
    localparam int unsigned CFG_PU    = 5;

    localparam logic [CFG_W-1:0] CFG_RESET = 6'b010010;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] QUIESCE = 2'd1;
    localparam logic [1:0] APPLY   = 2'd2;
    localparam logic [1:0] SETTLE  = 2'd3;

    function automatic logic cfg_legal(input logic [CFG_W-1:0] cfg);
        return ~(cfg[CFG_PU] & cfg[CFG_PD]);
    endfunction

endpackage

// File: rtl/tt_pad_in_filter.sv
// Pad input conditioning: two-flop synchroniser, glitch filter, edge detect.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   din         - asynchronous input level (already gated by the pad ie)
//   sig_in      - filtered level; follows the synchronised input once it has
//                 differed from sig_in for FILT_LEN consecutive cycles
//   sig_rise    - one-cycle pulse when sig_in goes 0->1
//   sig_fall    - one-cycle pulse when sig_in goes 1->0
module tt_pad_in_filter #(
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned FILT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sig_in,
    output logic sig_rise,
    output logic sig_fall
);

    logic s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    if (FILT_LEN == 0) begin : g_nofilt
        always_ff @(posedge clk) begin
            if (reset) begin
                sig_in   <= 1'b0;
                sig_rise <= 1'b0;
                sig_fall <= 1'b0;
            end else begin
                sig_in   <= s2_q;
                sig_rise <= s2_q & ~sig_in;
                sig_fall <= ~s2_q & sig_in;
            end
        end
    end else begin : g_filt
        logic [FILT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q    <= '0;
                sig_in   <= 1'b0;
                sig_rise <= 1'b0;
                sig_fall <= 1'b0;
            end else begin
                sig_rise <= 1'b0;
                sig_fall <= 1'b0;
                if (s2_q == sig_in) begin
                    // Any bounce back to the current level restarts the count.
                    cnt_q <= '0;
                end else if (cnt_q == FILT_W'(FILT_LEN - 1)) begin
                    sig_in   <= s2_q;
                    sig_rise <= s2_q;
                    sig_fall <= ~s2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + FILT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tt_pad_sig_ctrl.sv
// Core-side controller for one bidirectional signal pad.
// Attribute changes run IDLE -> QUIESCE (drive off) -> APPLY -> SETTLE -> IDLE
// so the pad never drives while its attributes are changing.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   pad_y                           - pad receiver output (asynchronous)
//   pad_a/oe/ie/sl/cs/pd/pu         - pad control pins
//   core_a, core_oe                 - data and drive request from user logic
//   sig_in, sig_rise, sig_fall      - filtered input level and edge pulses
//   cfg_wr, cfg_data                - config write strobe / {pu,pd,cs,sl,ie,oe_en}
//   cfg_busy                        - sequencer not idle
//   cfg_err                         - pulse: write rejected (pu&pd, or busy)
//   cfg_cur                         - configuration currently applied
module tt_pad_sig_ctrl
    import tt_pad_pkg::*;
#(
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned FILT_W     = 4,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad_y,
    output logic       pad_a,
    output logic       pad_oe,
    output logic       pad_ie,
    output logic       pad_sl,
    output logic       pad_cs,
    output logic       pad_pd,
    output logic       pad_pu,
    input  logic       core_a,
    input  logic       core_oe,
    output logic       sig_in,
    output logic       sig_rise,
    output logic       sig_fall,
    input  logic       cfg_wr,
    input  logic [5:0] cfg_data,
    output logic       cfg_busy,
    output logic       cfg_err,
    output logic [5:0] cfg_cur
);

    logic [1:0]       state_q, state_d;
    logic [CFG_W-1:0] pending_q;
    logic [CNT_W-1:0] settle_cnt_q;
    logic             idle;
    logic             accept;

    assign idle   = (state_q == IDLE);
    assign accept = cfg_wr & idle & cfg_legal(cfg_data);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = QUIESCE;
            QUIESCE: state_d = APPLY;
            APPLY:   state_d = SETTLE;
            SETTLE:  if (settle_cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= CFG_RESET;
            settle_cnt_q <= '0;
            cfg_cur      <= CFG_RESET;
            pad_a        <= 1'b0;
            pad_oe       <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state_q <= state_d;
            pad_a   <= core_a;
            // Drive drops the cycle after an accepted write and stays off
            // until the sequencer is back in IDLE.
            pad_oe  <= core_oe & cfg_cur[CFG_OE_EN] & idle & ~accept;
            cfg_err <= cfg_wr & ~accept;
            if (accept) pending_q <= cfg_data;
            if (state_q == APPLY) begin
                cfg_cur      <= pending_q;
                settle_cnt_q <= '0;
            end else if (state_q == SETTLE) begin
                settle_cnt_q <= settle_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cfg_busy = ~idle;
    assign pad_ie   = cfg_cur[CFG_IE];
    assign pad_sl   = cfg_cur[CFG_SL];
    assign pad_cs   = cfg_cur[CFG_CS];
    assign pad_pd   = cfg_cur[CFG_PD];
    assign pad_pu   = cfg_cur[CFG_PU];

    tt_pad_in_filter #(
        .FILT_LEN (FILT_LEN),
        .FILT_W   (FILT_W)
    ) u_in_filter (
        .clk      (clk),
        .reset    (reset),
        .din      (pad_y & cfg_cur[CFG_IE]),
        .sig_in   (sig_in),
        .sig_rise (sig_rise),
        .sig_fall (sig_fall)
    );

endmodule
